// File: rtl/ncmem_noc_pkt_buffer.sv
// ncmem_noc_pkt_buffer: store-and-forward NoC2 request buffer in the mc_clk domain.
// Define NCMEM_PKT_BUF_STATS_EN to add the stat_pkts_in / stat_pkts_drop counters.
module ncmem_noc_pkt_buffer #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int LEN_LSB = 22,
  parameter int LEN_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_val,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_rdy,
  output logic                   out_val,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_rdy,
  output logic [$clog2(DEPTH):0] pkt_cnt,
  output logic                   drop_err
`ifdef NCMEM_PKT_BUF_STATS_EN
  ,
  output logic [31:0]            stat_pkts_in,
  output logic [15:0]            stat_pkts_drop
`endif
);

  // Handshake: a flit moves on a rising clk edge where valid & ready are both 1;
  // valid never waits on ready, and payload is sampled only on that edge.

  localparam int AW = $clog2(DEPTH);
  localparam int MAX_LEN = DEPTH - 1;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [AW:0]      CNT_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  typedef enum logic [1:0] {IN_HDR, IN_BODY, IN_DROP} in_state_t;
  typedef enum logic {OUT_HDR, OUT_BODY} out_state_t;

  in_state_t  in_state, in_state_nx;
  out_state_t out_state, out_state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [LEN_W-1:0]  rem, rem_nx;
  logic [LEN_W-1:0]  orem, orem_nx;
  logic [LEN_W-1:0]  in_len, out_len;
  logic              full, in_acc, pop, oversize;
  logic              wr_en, complete, finished, drop_hdr;

  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // No read bypass: a full buffer refuses input even in a cycle that pops.
  assign in_rdy   = !rst && ((in_state == IN_DROP) || !full);
  assign in_acc   = in_val && in_rdy;
  assign out_val  = (pkt_cnt != '0);
  assign pop      = out_val && out_rdy;
  assign out_data = mem[rd_ptr[AW-1:0]];
  assign in_len   = in_data[LEN_LSB +: LEN_W];
  assign out_len  = out_data[LEN_LSB +: LEN_W];
  assign oversize = (32'(in_len) > MAX_LEN);

  // Input side: headers decide store vs. drop; body flits count down rem.
  always_comb begin
    in_state_nx = in_state;
    rem_nx      = rem;
    wr_en       = 1'b0;
    complete    = 1'b0;
    drop_hdr    = 1'b0;
    if (in_acc) begin
      case (in_state)
        IN_HDR: begin
          rem_nx = in_len;
          if (oversize) begin
            drop_hdr = 1'b1;
            if (in_len != '0) in_state_nx = IN_DROP;
          end else begin
            wr_en = 1'b1;
            if (in_len != '0) in_state_nx = IN_BODY;
            else              complete    = 1'b1;
          end
        end
        IN_BODY: begin
          wr_en  = 1'b1;
          rem_nx = rem - LEN_ONE;
          if (rem == LEN_ONE) begin
            complete    = 1'b1;
            in_state_nx = IN_HDR;
          end
        end
        IN_DROP: begin
          rem_nx = rem - LEN_ONE;
          if (rem == LEN_ONE) in_state_nx = IN_HDR;
        end
        default: in_state_nx = IN_HDR;
      endcase
    end
  end

  // Output side: track packet boundaries so pkt_cnt drops on the last flit out.
  always_comb begin
    out_state_nx = out_state;
    orem_nx      = orem;
    finished     = 1'b0;
    if (pop) begin
      case (out_state)
        OUT_HDR: begin
          orem_nx = out_len;
          if (out_len != '0) out_state_nx = OUT_BODY;
          else               finished     = 1'b1;
        end
        OUT_BODY: begin
          orem_nx = orem - LEN_ONE;
          if (orem == LEN_ONE) begin
            finished     = 1'b1;
            out_state_nx = OUT_HDR;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state  <= IN_HDR;
      out_state <= OUT_HDR;
      rem       <= '0;
      orem      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_cnt   <= '0;
      drop_err  <= 1'b0;
    end else begin
      in_state  <= in_state_nx;
      out_state <= out_state_nx;
      rem       <= rem_nx;
      orem      <= orem_nx;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (complete && !finished)      pkt_cnt <= pkt_cnt + CNT_ONE;
      else if (!complete && finished) pkt_cnt <= pkt_cnt - CNT_ONE;
      if (drop_hdr) drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
  end

`ifdef NCMEM_PKT_BUF_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts_in   <= '0;
      stat_pkts_drop <= '0;
    end else begin
      if (complete) stat_pkts_in <= stat_pkts_in + 32'd1;
      if (drop_hdr && (stat_pkts_drop != 16'hFFFF)) stat_pkts_drop <= stat_pkts_drop + 16'd1;
    end
  end
`endif

endmodule
